// File: rtl/riscv_definitions.sv
// Shared types for the execute stage: data bus width, register address width
// and the ALU operation encoding.
package riscv_definitions;

  typedef logic [31:0] dataBus_t;

  localparam int REG_ADDR = 5;

  // Encoding 4'hF is left unassigned; the ALU returns 0 for it.
  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_AND    = 4'd2,
    ALU_OR     = 4'd3,
    ALU_XOR    = 4'd4,
    ALU_SLL    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_LT     = 4'd8,
    ALU_LTU    = 4'd9,
    ALU_EQUAL  = 4'd10,
    ALU_NEQUAL = 4'd11,
    ALU_GE     = 4'd12,
    ALU_GEU    = 4'd13,
    ALU_BPS2   = 4'd14
  } aluOpType;

endpackage

// File: rtl/execution_alu.sv
// Combinational 32-bit ALU. Compare ops return 1/0 in bit 0 so the branch
// logic can use result[0] directly.
module alu
  import riscv_definitions::*;
(
  input  aluOpType alu_op,
  input  dataBus_t a,
  input  dataBus_t b,
  output dataBus_t result
);

  logic [4:0] shamt;

  assign shamt = b[4:0];

  // Operation select; unknown op codes fall through to zero.
  always_comb begin
    result = '0;
    case (alu_op)
      ALU_ADD:    result = a + b;
      ALU_SUB:    result = a - b;
      ALU_AND:    result = a & b;
      ALU_OR:     result = a | b;
      ALU_XOR:    result = a ^ b;
      ALU_SLL:    result = a << shamt;
      ALU_SRL:    result = a >> shamt;
      ALU_SRA:    result = dataBus_t'($signed(a) >>> shamt);
      ALU_LT:     result = {31'b0, $signed(a) < $signed(b)};
      ALU_LTU:    result = {31'b0, a < b};
      ALU_EQUAL:  result = {31'b0, a == b};
      ALU_NEQUAL: result = {31'b0, a != b};
      ALU_GE:     result = {31'b0, $signed(a) >= $signed(b)};
      ALU_GEU:    result = {31'b0, a >= b};
      ALU_BPS2:   result = b;
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/execution.sv
// Execute stage: operand muxes, ALU, branch/jump redirect and the EX/MEM
// pipeline register. Optional macro EX_REGISTERED_REDIRECT_EN moves the
// redirect (flush + target) behind the same register as the other outputs.
module execution
  import riscv_definitions::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clk_en,
  input  logic                i_id_mem_to_reg,
  input  logic                i_id_alu_src1,
  input  logic                i_id_alu_src2,
  input  logic                i_id_reg_wr,
  input  logic                i_id_mem_rd,
  input  logic                i_id_mem_wr,
  input  logic                i_id_result_src,
  input  logic                i_id_branch,
  input  logic                i_id_jump,
  input  aluOpType            i_id_alu_op,
  input  dataBus_t            i_id_pc,
  input  dataBus_t            i_id_reg_read_data1,
  input  dataBus_t            i_id_reg_read_data2,
  input  dataBus_t            i_id_imm,
  input  logic [REG_ADDR-1:0] i_id_reg_destination,
  input  logic [2:0]          i_id_funct3,
  input  logic [6:0]          i_id_funct7,
  output logic                o_ex_flush,
  output dataBus_t            o_ex_jump_addr,
  output logic                o_ex_mem_to_reg,
  output logic                o_ex_reg_wr,
  output logic                o_ex_mem_rd,
  output logic                o_ex_mem_wr,
  output logic                o_ex_result_src,
  output dataBus_t            o_ex_pc_plus_4,
  output dataBus_t            o_ex_alu_result,
  output dataBus_t            o_ex_data2,
  output logic [REG_ADDR-1:0] o_ex_reg_destination,
  output logic [2:0]          o_ex_funct3,
  output logic [6:0]          o_ex_funct7
);

  dataBus_t op_a;
  dataBus_t op_b;
  dataBus_t alu_result;
  logic     branch_taken;
  logic     flush_next;
  dataBus_t jump_addr_next;

  assign op_a = i_id_alu_src1 ? i_id_pc  : i_id_reg_read_data1;
  assign op_b = i_id_alu_src2 ? i_id_imm : i_id_reg_read_data2;

  alu u_alu (
    .alu_op (i_id_alu_op),
    .a      (op_a),
    .b      (op_b),
    .result (alu_result)
  );

  // Branches compute their condition in the ALU, so the target needs its own
  // adder; jumps reuse the ALU sum (PC+imm or rs1+imm).
  always_comb begin
    branch_taken   = i_id_branch & alu_result[0];
    flush_next     = i_id_jump | branch_taken;
    jump_addr_next = branch_taken ? (i_id_pc + i_id_imm) : alu_result;
  end

  // EX/MEM pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_ex_mem_to_reg      <= 1'b0;
      o_ex_reg_wr          <= 1'b0;
      o_ex_mem_rd          <= 1'b0;
      o_ex_mem_wr          <= 1'b0;
      o_ex_result_src      <= 1'b0;
      o_ex_pc_plus_4       <= '0;
      o_ex_alu_result      <= '0;
      o_ex_data2           <= '0;
      o_ex_reg_destination <= '0;
      o_ex_funct3          <= '0;
      o_ex_funct7          <= '0;
    end else if (clk_en) begin
      o_ex_mem_to_reg      <= i_id_mem_to_reg;
      o_ex_reg_wr          <= i_id_reg_wr;
      o_ex_mem_rd          <= i_id_mem_rd;
      o_ex_mem_wr          <= i_id_mem_wr;
      o_ex_result_src      <= i_id_result_src;
      o_ex_pc_plus_4       <= i_id_pc + 32'd4;
      o_ex_alu_result      <= alu_result;
      o_ex_data2           <= i_id_reg_read_data2;
      o_ex_reg_destination <= i_id_reg_destination;
      o_ex_funct3          <= i_id_funct3;
      o_ex_funct7          <= i_id_funct7;
    end
  end

`ifdef EX_REGISTERED_REDIRECT_EN
  // Redirect registered alongside EX/MEM to shorten the fetch-side path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_ex_flush     <= 1'b0;
      o_ex_jump_addr <= '0;
    end else if (clk_en) begin
      o_ex_flush     <= flush_next;
      o_ex_jump_addr <= jump_addr_next;
    end
  end
`else
  assign o_ex_flush     = flush_next;
  assign o_ex_jump_addr = jump_addr_next;
`endif

endmodule

// File: tb/tb_execution.sv
// Self-checking bench for the execute stage: directed vector table, clock
// enable hold, asynchronous reset, and randomized stimulus against a model.
module tb_execution;
  import riscv_definitions::*;

  typedef struct {
    logic        mem_to_reg, alu_src1, alu_src2, reg_wr, mem_rd, mem_wr;
    logic        result_src, branch, jump;
    logic [3:0]  op;
    logic [31:0] pc, rs1, rs2, imm;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
  } in_t;

  typedef struct {
    logic        mem_to_reg, reg_wr, mem_rd, mem_wr, result_src;
    logic [31:0] pc4, res, data2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
  } regs_t;

  typedef struct {
    string       name;
    in_t         in;
    logic [31:0] exp_res;
    logic        exp_flush;
    logic [31:0] exp_jaddr;
  } vec_t;

  logic clk = 1'b0;
  logic rst, clk_en;
  logic mem_to_reg, alu_src1, alu_src2, reg_wr, mem_rd, mem_wr, result_src, branch, jump;
  aluOpType alu_op;
  logic [31:0] pc, rs1, rs2, imm;
  logic [4:0] rd;
  logic [2:0] f3;
  logic [6:0] f7;
  logic o_flush, o_mem_to_reg, o_reg_wr, o_mem_rd, o_mem_wr, o_result_src;
  logic [31:0] o_jaddr, o_pc4, o_res, o_data2;
  logic [4:0] o_rd;
  logic [2:0] o_f3;
  logic [6:0] o_f7;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  execution dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .i_id_mem_to_reg(mem_to_reg), .i_id_alu_src1(alu_src1), .i_id_alu_src2(alu_src2),
    .i_id_reg_wr(reg_wr), .i_id_mem_rd(mem_rd), .i_id_mem_wr(mem_wr),
    .i_id_result_src(result_src), .i_id_branch(branch), .i_id_jump(jump),
    .i_id_alu_op(alu_op), .i_id_pc(pc), .i_id_reg_read_data1(rs1),
    .i_id_reg_read_data2(rs2), .i_id_imm(imm), .i_id_reg_destination(rd),
    .i_id_funct3(f3), .i_id_funct7(f7),
    .o_ex_flush(o_flush), .o_ex_jump_addr(o_jaddr),
    .o_ex_mem_to_reg(o_mem_to_reg), .o_ex_reg_wr(o_reg_wr), .o_ex_mem_rd(o_mem_rd),
    .o_ex_mem_wr(o_mem_wr), .o_ex_result_src(o_result_src),
    .o_ex_pc_plus_4(o_pc4), .o_ex_alu_result(o_res), .o_ex_data2(o_data2),
    .o_ex_reg_destination(o_rd), .o_ex_funct3(o_f3), .o_ex_funct7(o_f7)
  );

  // Reference ALU from plain integer arithmetic.
  function automatic logic [31:0] ref_alu(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    longint pw = longint'(1) << int'(b[4:0]);
    case (op)
      4'd0:  return 32'(ua + ub);
      4'd1:  return 32'(ua - ub);
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return 32'(ua * pw);
      4'd6:  return 32'(ua / pw);
      4'd7:  return 32'((sa < 0) ? ((sa - pw + 1) / pw) : (sa / pw));
      4'd8:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd9:  return (ua < ub) ? 32'd1 : 32'd0;
      4'd10: return (ua == ub) ? 32'd1 : 32'd0;
      4'd11: return (ua != ub) ? 32'd1 : 32'd0;
      4'd12: return (sa >= sb) ? 32'd1 : 32'd0;
      4'd13: return (ua >= ub) ? 32'd1 : 32'd0;
      4'd14: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] model_res(in_t x);
    return ref_alu(x.op, x.alu_src1 ? x.pc : x.rs1, x.alu_src2 ? x.imm : x.rs2);
  endfunction

  function automatic logic model_taken(in_t x);
    logic [31:0] r = model_res(x);
    return x.branch && (r % 2 == 1);
  endfunction

  function automatic logic model_flush(in_t x);
    return x.jump || model_taken(x);
  endfunction

  function automatic logic [31:0] model_jaddr(in_t x);
    return model_taken(x) ? 32'(x.pc + x.imm) : model_res(x);
  endfunction

  function automatic regs_t model_regs(in_t x);
    regs_t r;
    r.mem_to_reg = x.mem_to_reg; r.reg_wr = x.reg_wr; r.mem_rd = x.mem_rd;
    r.mem_wr = x.mem_wr; r.result_src = x.result_src;
    r.pc4 = 32'(x.pc + 4); r.res = model_res(x); r.data2 = x.rs2;
    r.rd = x.rd; r.f3 = x.f3; r.f7 = x.f7;
    return r;
  endfunction

  function automatic regs_t zero_regs();
    regs_t r;
    r.mem_to_reg = 0; r.reg_wr = 0; r.mem_rd = 0; r.mem_wr = 0; r.result_src = 0;
    r.pc4 = 0; r.res = 0; r.data2 = 0; r.rd = 0; r.f3 = 0; r.f7 = 0;
    return r;
  endfunction

  function automatic in_t blank_in();
    in_t x;
    x.mem_to_reg = 0; x.alu_src1 = 0; x.alu_src2 = 0; x.reg_wr = 0; x.mem_rd = 0;
    x.mem_wr = 0; x.result_src = 0; x.branch = 0; x.jump = 0; x.op = 4'd0;
    x.pc = 0; x.rs1 = 0; x.rs2 = 0; x.imm = 0; x.rd = 0; x.f3 = 0; x.f7 = 0;
    return x;
  endfunction

  function automatic in_t rand_in();
    in_t x;
    x.mem_to_reg = 1'($urandom); x.alu_src1 = 1'($urandom); x.alu_src2 = 1'($urandom);
    x.reg_wr = 1'($urandom); x.mem_rd = 1'($urandom); x.mem_wr = 1'($urandom);
    x.result_src = 1'($urandom); x.branch = 1'($urandom);
    x.jump = ($urandom_range(0, 3) == 0);
    x.op = 4'($urandom_range(0, 15));
    x.pc = $urandom & 32'hFFFF_FFFC; x.rs1 = $urandom; x.imm = $urandom;
    case ($urandom_range(0, 3))
      0: x.rs2 = x.rs1;
      1: x.rs2 = 32'($urandom_range(0, 40));
      default: x.rs2 = $urandom;
    endcase
    if ($urandom_range(0, 3) == 0) x.imm = x.rs1;
    x.rd = 5'($urandom); x.f3 = 3'($urandom); x.f7 = 7'($urandom);
    return x;
  endfunction

  task automatic drive(in_t x);
    mem_to_reg = x.mem_to_reg; alu_src1 = x.alu_src1; alu_src2 = x.alu_src2;
    reg_wr = x.reg_wr; mem_rd = x.mem_rd; mem_wr = x.mem_wr; result_src = x.result_src;
    branch = x.branch; jump = x.jump; alu_op = aluOpType'(x.op);
    pc = x.pc; rs1 = x.rs1; rs2 = x.rs2; imm = x.imm; rd = x.rd; f3 = x.f3; f7 = x.f7;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_comb(string nm, in_t x);
    chk({nm, ".flush"}, 32'(o_flush), 32'(model_flush(x)));
    chk({nm, ".jump_addr"}, o_jaddr, model_jaddr(x));
  endtask

  task automatic check_regs(string nm, regs_t e);
    chk({nm, ".mem_to_reg"}, 32'(o_mem_to_reg), 32'(e.mem_to_reg));
    chk({nm, ".reg_wr"}, 32'(o_reg_wr), 32'(e.reg_wr));
    chk({nm, ".mem_rd"}, 32'(o_mem_rd), 32'(e.mem_rd));
    chk({nm, ".mem_wr"}, 32'(o_mem_wr), 32'(e.mem_wr));
    chk({nm, ".result_src"}, 32'(o_result_src), 32'(e.result_src));
    chk({nm, ".pc_plus_4"}, o_pc4, e.pc4);
    chk({nm, ".alu_result"}, o_res, e.res);
    chk({nm, ".data2"}, o_data2, e.data2);
    chk({nm, ".rd"}, 32'(o_rd), 32'(e.rd));
    chk({nm, ".funct3"}, 32'(o_f3), 32'(e.f3));
    chk({nm, ".funct7"}, 32'(o_f7), 32'(e.f7));
  endtask

  vec_t  vecs[$];
  regs_t exp_regs;
  in_t   cur;

  task automatic add_vec(string nm, in_t x, logic [31:0] r, logic f, logic [31:0] j);
    vec_t v;
    v.name = nm; v.in = x; v.exp_res = r; v.exp_flush = f; v.exp_jaddr = j;
    vecs.push_back(v);
  endtask

  initial begin
    in_t x;

    // Directed table with hand-derived expectations.
    x = blank_in(); x.op = 4'd0; x.rs1 = 5; x.rs2 = 3; x.reg_wr = 1; x.rd = 5'd7; x.f7 = 7'h20;
    add_vec("add", x, 32'd8, 1'b0, 32'd8);
    x = blank_in(); x.op = 4'd0; x.rs1 = 7; x.imm = 4; x.alu_src2 = 1; x.rs2 = 32'h55; x.f3 = 3'd2;
    add_vec("addi", x, 32'd11, 1'b0, 32'd11);
    x = blank_in(); x.op = 4'd8; x.rs1 = 2; x.rs2 = 5; x.mem_to_reg = 1; x.result_src = 1;
    add_vec("slt", x, 32'd1, 1'b0, 32'd1);
    x = blank_in(); x.op = 4'd0; x.pc = 32'h1000_000C; x.imm = 16; x.alu_src1 = 1;
    x.alu_src2 = 1; x.jump = 1; x.reg_wr = 1; x.rd = 5'd1;
    add_vec("jal", x, 32'h1000_001C, 1'b1, 32'h1000_001C);
    x = blank_in(); x.op = 4'd11; x.pc = 32'h1000_0014; x.rs1 = 10; x.rs2 = 4; x.imm = 8;
    x.branch = 1; x.f3 = 3'd1;
    add_vec("bne_taken", x, 32'd1, 1'b1, 32'h1000_001C);
    x = blank_in(); x.op = 4'd11; x.pc = 32'h1000_0014; x.rs1 = 4; x.rs2 = 4; x.imm = 8; x.branch = 1;
    add_vec("bne_not", x, 32'd0, 1'b0, 32'd0);
    x = blank_in(); x.op = 4'd9; x.rs1 = 32'hFFFF_FFFF; x.rs2 = 1; x.mem_wr = 1;
    add_vec("ltu", x, 32'd0, 1'b0, 32'd0);
    x = blank_in(); x.op = 4'd10; x.pc = 32'h100; x.rs1 = 9; x.rs2 = 9; x.imm = 32'h20;
    x.branch = 1; x.jump = 1;
    add_vec("jump_and_branch", x, 32'd1, 1'b1, 32'h120);
    x = blank_in(); x.op = 4'd15; x.rs1 = 5; x.rs2 = 3; x.mem_rd = 1;
    add_vec("undef_op", x, 32'd0, 1'b0, 32'd0);
    x = blank_in(); x.op = 4'd7; x.rs1 = 32'h8000_0000; x.rs2 = 32'h24;
    add_vec("sra", x, 32'hF800_0000, 1'b0, 32'hF800_0000);
    x = blank_in(); x.op = 4'd0; x.rs1 = 1; x.rs2 = 1; x.branch = 1; x.pc = 32'h40; x.imm = 32'h8;
    add_vec("branch_even_result", x, 32'd2, 1'b0, 32'd2);
    x = blank_in(); x.op = 4'd14; x.rs1 = 1; x.rs2 = 32'hDEAD_BEEF;
    add_vec("bps2", x, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF);
    x = blank_in(); x.op = 4'd5; x.rs1 = 32'h0000_0003; x.rs2 = 32'h1F;
    add_vec("sll31", x, 32'h8000_0000, 1'b0, 32'h8000_0000);
    x = blank_in(); x.op = 4'd12; x.rs1 = 32'hFFFF_FFFF; x.rs2 = 32'h0000_0001; x.branch = 1;
    add_vec("bge_neg", x, 32'd0, 1'b0, 32'd0);

    // Reset held: registers stay zero regardless of clock and enable.
    rst = 1'b1; clk_en = 1'b1;
    drive(vecs[0].in);
    #2;
    check_regs("reset_initial", zero_regs());
    repeat (2) @(posedge clk);
    #1;
    check_regs("reset_held", zero_regs());
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].in);
      #1;
      chk({vecs[i].name, ".flush"}, 32'(o_flush), 32'(vecs[i].exp_flush));
      chk({vecs[i].name, ".jump_addr"}, o_jaddr, vecs[i].exp_jaddr);
      @(posedge clk);
      #1;
      chk({vecs[i].name, ".result"}, o_res, vecs[i].exp_res);
      check_regs(vecs[i].name, model_regs(vecs[i].in));
    end
    exp_regs = model_regs(vecs[vecs.size() - 1].in);

    // Clock enable low: registers hold, redirect follows the new inputs.
    @(negedge clk);
    clk_en = 1'b0;
    cur = rand_in();
    drive(cur);
    repeat (3) @(posedge clk);
    #1;
    check_regs("hold", exp_regs);
    check_comb("hold_comb", cur);

    // Asynchronous reset mid-cycle.
    @(negedge clk);
    clk_en = 1'b1;
    cur = vecs[3].in;
    drive(cur);
    @(posedge clk);
    #1;
    check_regs("pre_reset", model_regs(cur));
    #2;
    rst = 1'b1;
    #1;
    check_regs("reset_async", zero_regs());
    check_comb("reset_comb", cur);
    repeat (2) @(posedge clk);
    #1;
    check_regs("reset_clocked", zero_regs());
    @(negedge clk);
    rst = 1'b0;
    cur = vecs[4].in;
    drive(cur);
    @(posedge clk);
    #1;
    check_regs("post_reset", model_regs(cur));
    exp_regs = model_regs(cur);

    // Randomized traffic with random clock enable.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      cur = rand_in();
      drive(cur);
      clk_en = ($urandom_range(0, 3) != 0);
      #1;
      check_comb("rand_comb", cur);
      @(posedge clk);
      #1;
      if (clk_en) exp_regs = model_regs(cur);
      check_regs("rand_regs", exp_regs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
